// File: rtl/dma_axi_simple_pkg.sv
// Shared definitions for the dma_axi_simple CSR bridges:
// FSM states, AXI burst codes and response codes.
package dma_axi_simple_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } csr_state_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/dma_axi_simple_csr_addr_next.sv
// Next beat address for AXI bursts into the CSR space.
// Shared by the CSR write and read bridges.
module dma_axi_simple_csr_addr_next
  import dma_axi_simple_pkg::*;
#(
  parameter int AW = 10,
  parameter int DS = 4
) (
  input  logic [AW-1:0] addr_i,
  input  logic [2:0]    size_i,
  input  burst_e        burst_i,
  output logic [AW-1:0] addr_o,
  output logic          err_o
);

  logic [AW-1:0] step;
  logic [AW-1:0] base;

  assign step = AW'(1) << size_i;
  assign base = addr_i & ~AW'(DS - 1);

  // Wide beats land on the next bus-aligned address.
  always_comb begin
    addr_o = addr_i;
    err_o  = 1'b0;
    unique case (burst_i)
      BURST_FIXED: addr_o = addr_i;
      BURST_INCR: begin
        if (step < AW'(DS)) addr_o = addr_i + step;
        else                addr_o = base + AW'(DS);
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dma_axi_simple_csr_wrtr.sv
// AXI4 slave write port into a 32-bit CSR bus.
// One transaction at a time, single-cycle TR_WREN per beat.
module dma_axi_simple_csr_wrtr
  import dma_axi_simple_pkg::*;
#(
  parameter int AXI_WIDTH_CID = 4,
  parameter int AXI_WIDTH_ID  = 4,
  parameter int AXI_WIDTH_AD  = 32,
  parameter int AXI_WIDTH_DA  = 32,
  parameter int AXI_WIDTH_DS  = AXI_WIDTH_DA / 8,
  parameter int AXI_WIDTH_SID = AXI_WIDTH_CID + AXI_WIDTH_ID,
  parameter int ADDR_LENGTH   = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [AXI_WIDTH_SID-1:0] S_AWID,
  input  logic [AXI_WIDTH_AD-1:0]  S_AWADDR,
  input  logic [7:0]               S_AWLEN,
  input  logic [2:0]               S_AWSIZE,
  input  logic [1:0]               S_AWBURST,
  input  logic                     S_AWVALID,
  output logic                     S_AWREADY,
  input  logic [AXI_WIDTH_DA-1:0]  S_WDATA,
  input  logic [AXI_WIDTH_DS-1:0]  S_WSTRB,
  input  logic                     S_WLAST,
  input  logic                     S_WVALID,
  output logic                     S_WREADY,
  output logic [AXI_WIDTH_SID-1:0] S_BID,
  output logic [1:0]               S_BRESP,
  output logic                     S_BVALID,
  input  logic                     S_BREADY,
  output logic                     TR_REQ,
  input  logic                     TR_GRT,
  output logic [ADDR_LENGTH-1:0]   TR_ADDR,
  output logic                     TR_WREN,
  output logic [31:0]              TR_WDATA,
  output logic [3:0]               TR_WSTRB
);

  localparam int AW    = ADDR_LENGTH + 2;
  localparam int LANES = AXI_WIDTH_DA / 32;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  csr_state_e               state_q;
  logic [AXI_WIDTH_SID-1:0] id_q;
  logic [AW-1:0]            addr_q;
  logic [AW-1:0]            addr_d;
  logic [7:0]               len_q;
  logic [7:0]               beat_q;
  logic [2:0]               size_q;
  burst_e                   burst_q;
  logic                     err_q;
  logic                     adv_err;
  logic                     awready_q;
  logic                     wready_q;
  logic                     bvalid_q;
  logic                     req_q;
  logic                     wren_q;
  logic [AXI_WIDTH_SID-1:0] bid_q;
  logic [1:0]               bresp_q;
  logic [ADDR_LENGTH-1:0]   traddr_q;
  logic [31:0]              wdata_q;
  logic [3:0]               wstrb_q;
  logic [31:0]              lane_data;
  logic [3:0]               lane_strb;
  logic                     last_beat;
  logic                     unused_awaddr;

  assign last_beat     = (beat_q == len_q);
  assign unused_awaddr = ^S_AWADDR[AXI_WIDTH_AD-1:AW];

  assign S_AWREADY = awready_q;
  assign S_WREADY  = wready_q;
  assign S_BVALID  = bvalid_q;
  assign S_BID     = bid_q;
  assign S_BRESP   = bresp_q;
  assign TR_REQ    = req_q;
  assign TR_ADDR   = traddr_q;
  assign TR_WREN   = wren_q;
  assign TR_WDATA  = wdata_q;
  assign TR_WSTRB  = wstrb_q;

  dma_axi_simple_csr_addr_next #(
    .AW(AW),
    .DS(AXI_WIDTH_DS)
  ) u_addr_next (
    .addr_i (addr_q),
    .size_i (size_q),
    .burst_i(burst_q),
    .addr_o (addr_d),
    .err_o  (adv_err)
  );

  // Pick the 32-bit lane addressed by the word offset.
  always_comb begin
    lane_data = S_WDATA[31:0];
    lane_strb = S_WSTRB[3:0];
    for (int i = 0; i < LANES; i++) begin
      if (LANES == 1 || addr_q[2 +: LW] == LW'(i)) begin
        lane_data = S_WDATA[32*i +: 32];
        lane_strb = S_WSTRB[4*i +: 4];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
      err_q     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      req_q     <= 1'b0;
      wren_q    <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      traddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (awready_q && S_AWVALID) begin
            id_q      <= S_AWID;
            addr_q    <= S_AWADDR[AW-1:0];
            len_q     <= S_AWLEN;
            size_q    <= S_AWSIZE;
            burst_q   <= burst_e'(S_AWBURST);
            beat_q    <= '0;
            err_q     <= 1'b0;
            awready_q <= 1'b0;
            req_q     <= 1'b1;
            state_q   <= TR_GRT ? ST_DATA : ST_ARB;
          end else begin
            awready_q <= 1'b1;
          end
        end
        ST_ARB: begin
          if (TR_GRT) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (!wready_q) begin
            wready_q <= 1'b1;
          end else if (S_WVALID) begin
            wready_q <= 1'b0;
            wren_q   <= 1'b1;
            traddr_q <= {addr_q[ADDR_LENGTH-1:2], 2'b00};
            wdata_q  <= lane_data;
            wstrb_q  <= lane_strb;
            if (S_WLAST != last_beat) err_q <= 1'b1;
            state_q  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          wren_q <= 1'b0;
          beat_q <= beat_q + 8'd1;
          if (last_beat) begin
            bvalid_q <= 1'b1;
            bid_q    <= id_q;
            bresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
            req_q    <= 1'b0;
            state_q  <= ST_RESP;
          end else begin
            addr_q  <= addr_d;
            if (adv_err) err_q <= 1'b1;
            state_q <= ST_DATA;
          end
        end
        ST_RESP: begin
          if (S_BREADY) begin
            bvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
